// File: rtl/bank_ram_pkg.sv
// Shared widths, bank word/vector types and PHY state encoding for the bank RAM
// arbiter and PHY.
package bank_ram_pkg;

    localparam int NUM_BANKS  = 5;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 9;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] bank_word_t;
    typedef bank_word_t [NUM_BANKS-1:0] bank_vec_t;

    typedef enum logic {INIT, RUN} phy_state_e;

    // Zero every bank whose mask bit is clear.
    function automatic bank_vec_t apply_mask(input bank_vec_t v, input logic [NUM_BANKS-1:0] m);
        bank_vec_t r;
        for (int b = 0; b < NUM_BANKS; b++) begin
            r[b] = m[b] ? v[b] : '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/bank_ram_if.sv
// Physical command and data links between the bank RAM arbiter and the PHY.
interface Bank_Cmd_If;
    import bank_ram_pkg::*;

    logic                 valid;
    logic                 rw;
    logic [NUM_BANKS-1:0] mask;
    logic [ADDR_WIDTH-1:0] addr;
    logic                 ready;

    modport Master (output valid, rw, mask, addr, input ready);
    modport Slave  (input valid, rw, mask, addr, output ready);
endinterface

interface Bank_Data_If;
    import bank_ram_pkg::*;

    logic      wvalid;
    bank_vec_t wdata;
    logic      wready;
    logic      rvalid;
    bank_vec_t rdata;

    modport Master (output wvalid, wdata, input wready, rvalid, rdata);
    modport Slave  (input wvalid, wdata, output wready, rvalid, rdata);
endinterface

// File: rtl/bank_sram_1p.sv
// One single-port SRAM bank: synchronous write, registered read-first output.
module bank_sram_1p #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/bank_ram_phy.sv
// Multi-bank SIMD RAM PHY: masked writes, fixed-latency masked reads.
// Optional power-up scrub of every word is enabled by BANK_RAM_SCRUB_EN.
module bank_ram_phy
    import bank_ram_pkg::*;
#(
    parameter int RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rstn,
    Bank_Cmd_If.Slave         cmd_if,
    Bank_Data_If.Slave        data_if,
    output logic              init_done,
    output logic              proto_err
);

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("bank_ram_phy: RD_LATENCY must be in 1..4");
    end

    phy_state_e            state, state_nxt;
    logic                  run;
    logic                  scrubbing;
    logic [ADDR_WIDTH-1:0] bank_addr;

`ifdef BANK_RAM_SCRUB_EN
    localparam logic [ADDR_WIDTH:0] SCRUB_ONE = 1;
    logic [ADDR_WIDTH:0] scrub_cnt, scrub_nxt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= INIT;
            scrub_cnt <= '0;
        end else begin
            state     <= state_nxt;
            scrub_cnt <= scrub_nxt;
        end
    end

    // Counter MSB sets on the increment past DEPTH-1, i.e. after the last word.
    always_comb begin
        state_nxt = state;
        scrub_nxt = scrub_cnt;
        if (state == INIT) begin
            scrub_nxt = scrub_cnt + SCRUB_ONE;
            if (scrub_nxt[ADDR_WIDTH]) begin
                state_nxt = RUN;
            end
        end
    end

    assign run       = (state == RUN);
    assign scrubbing = (state == INIT);
    assign bank_addr = scrubbing ? scrub_cnt[ADDR_WIDTH-1:0] : cmd_if.addr;
`else
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = RUN;
    end

    // Without a scrub the only hold-off is reset itself.
    assign run       = rstn && (state == RUN);
    assign scrubbing = 1'b0;
    assign bank_addr = cmd_if.addr;
`endif

    logic wr_cmd, wr_acc, rd_acc;

    assign cmd_if.ready   = run;
    assign init_done      = run;
    assign wr_cmd         = cmd_if.valid && run && cmd_if.rw;
    assign wr_acc         = wr_cmd && data_if.wvalid;
    assign rd_acc         = cmd_if.valid && run && !cmd_if.rw;
    assign data_if.wready = wr_acc;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            proto_err <= 1'b0;
        end else if (wr_cmd && !data_if.wvalid) begin
            proto_err <= 1'b1;
        end
    end

    logic [NUM_BANKS-1:0] bank_we;
    bank_vec_t            bank_din;
    bank_vec_t            dout_p0;

    assign bank_we  = scrubbing ? '1 : (wr_acc ? cmd_if.mask : '0);
    assign bank_din = scrubbing ? '0 : data_if.wdata;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        bank_sram_1p #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_bank (
            .clk (clk),
            .we  (bank_we[b]),
            .addr(bank_addr),
            .din (bank_din[b]),
            .dout(dout_p0[b])
        );
    end

    // Stage p0: bank output register; mask and valid are captured alongside.
    logic                 vld_p0;
    logic [NUM_BANKS-1:0] mask_p0;
    bank_vec_t            data_p0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= rd_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_acc) begin
            mask_p0 <= cmd_if.mask;
        end
    end

    assign data_p0 = apply_mask(dout_p0, mask_p0);

    logic      vld_last;
    bank_vec_t data_last;

    if (RD_LATENCY == 1) begin : g_lat1
        assign vld_last  = vld_p0;
        assign data_last = data_p0;
    end else begin : g_latn
        // Stages p1..pN: output registers, advanced only by a valid read.
        logic      vld_pn  [RD_LATENCY-1];
        bank_vec_t data_pn [RD_LATENCY-1];

        always_ff @(posedge clk) begin
            if (!rstn) begin
                for (int s = 0; s < RD_LATENCY-1; s++) begin
                    vld_pn[s] <= 1'b0;
                end
            end else begin
                vld_pn[0] <= vld_p0;
                for (int s = 1; s < RD_LATENCY-1; s++) begin
                    vld_pn[s] <= vld_pn[s-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (vld_p0) begin
                data_pn[0] <= data_p0;
            end
            for (int s = 1; s < RD_LATENCY-1; s++) begin
                if (vld_pn[s-1]) begin
                    data_pn[s] <= data_pn[s-1];
                end
            end
        end

        assign vld_last  = vld_pn[RD_LATENCY-2];
        assign data_last = data_pn[RD_LATENCY-2];
    end

    // rdata keeps the last returned word between pulses and clears on reset.
    bank_vec_t rdata_hold;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rdata_hold <= '0;
        end else if (vld_last) begin
            rdata_hold <= data_last;
        end
    end

    assign data_if.rvalid = vld_last;
    assign data_if.rdata  = vld_last ? data_last : rdata_hold;

endmodule

// File: tb/tb_bank_ram_phy.sv
// Scoreboard bench for bank_ram_phy; follows BANK_RAM_SCRUB_EN like the design.
module tb_bank_ram_phy;
    import bank_ram_pkg::*;

    localparam int RD_LATENCY = 2;
`ifdef BANK_RAM_SCRUB_EN
    localparam int INIT_WAIT = DEPTH;
`else
    localparam int INIT_WAIT = 1;
`endif

    logic clk;
    logic rstn;
    logic init_done;
    logic proto_err;

    Bank_Cmd_If  cmd_if ();
    Bank_Data_If data_if ();

    bank_ram_phy #(.RD_LATENCY(RD_LATENCY)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .cmd_if   (cmd_if),
        .data_if  (data_if),
        .init_done(init_done),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bank_vec_t data;
        int        due;
        int        id;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: every rvalid pulse must match the oldest outstanding read.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (data_if.rvalid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_rvalid: rdata %h with no read outstanding (cycle %0d)",
                             data_if.rdata, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (data_if.rdata !== e.data || cyc != e.due) begin
                        n_bad++;
                        $display("FAIL read_%0d: got %h at cycle %0d, expected %h at cycle %0d",
                                 e.id, data_if.rdata, cyc, e.data, e.due);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        @(negedge clk);
        cmd_if.valid   = 1'b0;
        data_if.wvalid = 1'b0;
    endtask

    task automatic wr(input logic [ADDR_WIDTH-1:0] a, input logic [NUM_BANKS-1:0] m,
                      input bank_vec_t d, input logic wv);
        @(negedge clk);
        cmd_if.valid   = 1'b1;
        cmd_if.rw      = 1'b1;
        cmd_if.addr    = a;
        cmd_if.mask    = m;
        data_if.wvalid = wv;
        data_if.wdata  = d;
        #1;
        chk("wready", {31'b0, data_if.wready}, {31'b0, wv});
    endtask

    task automatic rd(input logic [ADDR_WIDTH-1:0] a, input logic [NUM_BANKS-1:0] m,
                      input bank_vec_t expd, input int id, input bit push);
        exp_t e;
        @(negedge clk);
        cmd_if.valid   = 1'b1;
        cmd_if.rw      = 1'b0;
        cmd_if.addr    = a;
        cmd_if.mask    = m;
        data_if.wvalid = 1'b0;
        if (push) begin
            e.data = expd;
            e.due  = cyc + RD_LATENCY;
            e.id   = id;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) idle();
    endtask

    // Reset with a write command presented; nothing may respond.
    task automatic hold_reset(input int n);
        @(negedge clk);
        rstn           = 1'b0;
        cmd_if.valid   = 1'b1;
        cmd_if.rw      = 1'b1;
        cmd_if.addr    = '0;
        cmd_if.mask    = '1;
        data_if.wvalid = 1'b1;
        data_if.wdata  = {NUM_BANKS{32'h5555_AAAA}};
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rst_ready", {31'b0, cmd_if.ready}, 32'd0);
            chk("rst_init_done", {31'b0, init_done}, 32'd0);
            chk("rst_rvalid", {31'b0, data_if.rvalid}, 32'd0);
            chk("rst_wready", {31'b0, data_if.wready}, 32'd0);
            chk("rst_proto_err", {31'b0, proto_err}, 32'd0);
            chk("rst_rdata_b0", data_if.rdata[0], 32'd0);
        end
    endtask

    // Release reset and count cycles until ready; junk traffic during the scrub is ignored.
    task automatic release_wait(input logic junk_rw);
        int i;
        @(negedge clk);
        rstn           = 1'b1;
        data_if.wvalid = 1'b0;
`ifdef BANK_RAM_SCRUB_EN
        cmd_if.valid   = 1'b1;
        cmd_if.rw      = junk_rw;
`else
        cmd_if.valid   = 1'b0;
        cmd_if.rw      = junk_rw;
`endif
        i = 0;
        while (i < 600) begin
            @(negedge clk);
            i++;
            if (cmd_if.ready) break;
        end
        cmd_if.valid = 1'b0;
        chk("init_wait", i, INIT_WAIT);
        chk("init_done", {31'b0, init_done}, 32'd1);
        chk("proto_err_clear", {31'b0, proto_err}, 32'd0);
    endtask

    initial begin
        rstn           = 1'b0;
        cmd_if.valid   = 1'b0;
        cmd_if.rw      = 1'b0;
        cmd_if.mask    = '0;
        cmd_if.addr    = '0;
        data_if.wvalid = 1'b0;
        data_if.wdata  = '0;

        hold_reset(3);
        release_wait(1'b0);

`ifdef BANK_RAM_SCRUB_EN
        rd(9'h000, 5'b11111, '0, 1, 1'b1);
        rd(9'h1FF, 5'b11111, '0, 2, 1'b1);
        drain();
`else
        wr(9'h1FF, 5'b11111, '0, 1'b1);
`endif

        wr(9'h1FF, 5'b10101, {32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b1);
        rd(9'h1FF, 5'b11111, {32'hA4, 32'h0, 32'hA2, 32'h0, 32'hA0}, 3, 1'b1);
        drain();

        wr(9'h001, 5'b11111, {NUM_BANKS{32'h11}}, 1'b1);
        wr(9'h002, 5'b11111, {NUM_BANKS{32'h22}}, 1'b1);
        wr(9'h003, 5'b11111, {NUM_BANKS{32'h33}}, 1'b1);
        rd(9'h001, 5'b11111, {NUM_BANKS{32'h11}}, 4, 1'b1);
        rd(9'h002, 5'b11111, {NUM_BANKS{32'h22}}, 5, 1'b1);
        rd(9'h003, 5'b11111, {NUM_BANKS{32'h33}}, 6, 1'b1);
        drain();

        wr(9'h007, 5'b11111, {NUM_BANKS{32'hDEADBEEF}}, 1'b1);
        rd(9'h007, 5'b11111, {NUM_BANKS{32'hDEADBEEF}}, 7, 1'b1);
        rd(9'h007, 5'b00001, {32'h0, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, 8, 1'b1);
        idle();
        chk("rdata_hold_b0", data_if.rdata[0], 32'hDEADBEEF);
        drain();
        chk("rdata_hold_b1", data_if.rdata[1], 32'h0);

        wr(9'h004, 5'b11111, {NUM_BANKS{32'h44}}, 1'b1);
        idle();
        chk("proto_err_before", {31'b0, proto_err}, 32'd0);
        wr(9'h004, 5'b11111, {NUM_BANKS{32'h99}}, 1'b0);
        idle();
        chk("proto_err_set", {31'b0, proto_err}, 32'd1);
        drain();
        chk("proto_err_sticky", {31'b0, proto_err}, 32'd1);
        rd(9'h004, 5'b11111, {NUM_BANKS{32'h44}}, 9, 1'b1);
        drain();

        rd(9'h003, 5'b11111, '0, 0, 1'b0);
        hold_reset(4);
        release_wait(1'b1);

`ifdef BANK_RAM_SCRUB_EN
        rd(9'h007, 5'b11111, '0, 10, 1'b1);
`else
        wr(9'h009, 5'b11111, {NUM_BANKS{32'h5A5A_0F0F}}, 1'b1);
        rd(9'h009, 5'b11110, {32'h5A5A_0F0F, 32'h5A5A_0F0F, 32'h5A5A_0F0F, 32'h5A5A_0F0F, 32'h0}, 10, 1'b1);
`endif
        drain();

        chk("outstanding_reads", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
